// File: rtl/quiz_arbiter.sv
// quiz_arbiter: first-responder arbitration, lockout, answer-window timer
// and buzzer pulse generation for the quiz responder board.
module quiz_arbiter #(
  parameter int ANSWER_CYCLES = 500_000_000,
  parameter int BEEP_CYCLES   = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_flag,
  input  logic       start_flag,
  input  logic       clear_flag,
  output logic [3:0] led,
  output logic [1:0] winner_id,
  output logic       winner_valid,
  output logic       armed,
  output logic       foul,
  output logic       timeout,
  output logic       beep
);

  localparam int AW = $clog2(ANSWER_CYCLES + 1);
  localparam int BW = $clog2(BEEP_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    ANSWER,
    FOUL,
    TIMEOUT
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [AW-1:0]   ans_cnt;
  logic [AW-1:0]   ans_cnt_n;
  logic [BW-1:0]   beep_cnt;
  logic [BW-1:0]   beep_cnt_n;
  logic [3:0]      led_n;
  logic [1:0]      id_n;
  logic            valid_n;
  logic            beep_start;
  logic [1:0]      pick;

  // lowest-index pressed key wins a tie
  always_comb begin
    pick = '0;
    for (int i = 3; i >= 0; i--) begin
      if (key_flag[i]) pick = 2'(i);
    end
  end

  always_comb begin
    state_n    = state;
    ans_cnt_n  = ans_cnt;
    led_n      = led;
    id_n       = winner_id;
    valid_n    = winner_valid;
    beep_start = 1'b0;
    if (clear_flag) begin
      state_n   = IDLE;
      ans_cnt_n = '0;
      led_n     = '0;
      id_n      = '0;
      valid_n   = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_flag) begin
            state_n = ARMED;
          end else if (|key_flag) begin
            state_n    = FOUL;
            led_n      = key_flag;
            beep_start = 1'b1;
          end
        end
        ARMED: begin
          if (|key_flag) begin
            state_n    = ANSWER;
            led_n      = 4'b0001 << pick;
            id_n       = pick;
            valid_n    = 1'b1;
            ans_cnt_n  = '0;
            beep_start = 1'b1;
          end
        end
        ANSWER: begin
          if (ans_cnt == AW'(ANSWER_CYCLES - 1)) begin
            state_n    = TIMEOUT;
            ans_cnt_n  = AW'(ANSWER_CYCLES);
            beep_start = 1'b1;
          end else begin
            ans_cnt_n = ans_cnt + AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // each start event reloads the full pulse length
  always_comb begin
    beep_cnt_n = beep_cnt;
    if (clear_flag) begin
      beep_cnt_n = '0;
    end else if (beep_start) begin
      beep_cnt_n = BW'(BEEP_CYCLES);
    end else if (beep_cnt != '0) begin
      beep_cnt_n = beep_cnt - BW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ans_cnt      <= '0;
      beep_cnt     <= '0;
      led          <= '0;
      winner_id    <= '0;
      winner_valid <= 1'b0;
      armed        <= 1'b0;
      foul         <= 1'b0;
      timeout      <= 1'b0;
      beep         <= 1'b0;
    end else begin
      state        <= state_n;
      ans_cnt      <= ans_cnt_n;
      beep_cnt     <= beep_cnt_n;
      led          <= led_n;
      winner_id    <= id_n;
      winner_valid <= valid_n;
      armed        <= (state_n == ARMED);
      foul         <= (state_n == FOUL);
      timeout      <= (state_n == TIMEOUT);
      beep         <= (beep_cnt_n != '0);
    end
  end

endmodule

// File: tb/tb_quiz_arbiter.sv
// tb_quiz_arbiter: directed vectors with hand-computed expectations,
// checked by a queue-based scoreboard monitor one cycle behind the driver.
module tb_quiz_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] key_flag = '0;
  logic       start_flag = 1'b0;
  logic       clear_flag = 1'b0;
  logic [3:0] led;
  logic [1:0] winner_id;
  logic       winner_valid;
  logic       armed;
  logic       foul;
  logic       timeout;
  logic       beep;

  typedef struct packed {
    logic [3:0] led;
    logic [1:0] id;
    logic       valid;
    logic       armed;
    logic       foul;
    logic       timeout;
    logic       beep;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_fail = 0;
  bit    drive_done = 1'b0;

  quiz_arbiter #(
    .ANSWER_CYCLES(100),
    .BEEP_CYCLES  (10)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_flag    (key_flag),
    .start_flag  (start_flag),
    .clear_flag  (clear_flag),
    .led         (led),
    .winner_id   (winner_id),
    .winner_valid(winner_valid),
    .armed       (armed),
    .foul        (foul),
    .timeout     (timeout),
    .beep        (beep)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(logic [3:0] l, logic [1:0] i,
                              logic v, logic a, logic f,
                              logic t, logic b);
    exp_t e;
    e.led = l; e.id = i; e.valid = v; e.armed = a;
    e.foul = f; e.timeout = t; e.beep = b;
    return e;
  endfunction

  localparam exp_t Z   = '0;
  localparam exp_t ARM = 11'b0000_00_0_1_0_0_0;

  task automatic cyc(input logic r, input logic c, input logic s,
                     input logic [3:0] k, input exp_t e,
                     input string nm);
    @(negedge clk);
    rst        = r;
    clear_flag = c;
    start_flag = s;
    key_flag   = k;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // monitor: outputs settle #1 after the edge that consumed the vector
  initial begin
    exp_t  e;
    exp_t  got;
    string nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        got = {led, winner_id, winner_valid, armed, foul, timeout, beep};
        n_checks++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL %s: got led=%b id=%0d v=%b a=%b f=%b t=%b b=%b, required led=%b id=%0d v=%b a=%b f=%b t=%b b=%b",
                   nm, got.led, got.id, got.valid, got.armed, got.foul,
                   got.timeout, got.beep, e.led, e.id, e.valid, e.armed,
                   e.foul, e.timeout, e.beep);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1. reset with keys held, then quiet
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 4'b1111, Z, "reset");
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 4'b0000, Z, "post_reset");

    // 2. normal capture, 10-cycle beep, later keys ignored
    cyc(0, 0, 1, 4'b0000, ARM, "arm");
    cyc(0, 0, 0, 4'b0100, mk(4'b0100, 2, 1, 0, 0, 0, 1), "capture_p2");
    for (int i = 1; i <= 11; i++)
      cyc(0, 0, (i == 5), (i == 3) ? 4'b0001 : 4'b0000,
          mk(4'b0100, 2, 1, 0, 0, 0, (i <= 9)), "answer_hold");
    cyc(0, 1, 0, 4'b0000, Z, "clear_after_answer");

    // 3. tie resolves low; start+key in IDLE arms only
    cyc(0, 0, 1, 4'b0000, ARM, "arm_tie");
    cyc(0, 0, 0, 4'b1010, mk(4'b0010, 1, 1, 0, 0, 0, 1), "tie_1010");
    cyc(0, 1, 0, 4'b0000, Z, "clear_tie");
    cyc(0, 0, 1, 4'b0001, ARM, "start_key_same");
    cyc(0, 0, 0, 4'b0000, ARM, "armed_hold");
    cyc(0, 1, 0, 4'b0000, Z, "clear_armed");

    // 4. foul with mask, inputs ignored, then clear
    cyc(0, 0, 0, 4'b1001, mk(4'b1001, 0, 0, 0, 1, 0, 1), "foul_1001");
    for (int i = 1; i <= 11; i++)
      cyc(0, 0, (i == 2), (i == 5) ? 4'b0110 : 4'b0000,
          mk(4'b1001, 0, 0, 0, 1, 0, (i <= 9)), "foul_hold");
    cyc(0, 1, 0, 4'b0000, Z, "clear_foul");
    cyc(0, 0, 0, 4'b0000, Z, "idle_after_foul");

    // 5. timeout exactly 100 cycles after capture, beep restarts
    cyc(0, 0, 1, 4'b0000, ARM, "arm_to");
    cyc(0, 0, 0, 4'b1000, mk(4'b1000, 3, 1, 0, 0, 0, 1), "capture_p3");
    for (int i = 1; i <= 99; i++)
      cyc(0, 0, 0, 4'b0000,
          mk(4'b1000, 3, 1, 0, 0, 0, (i <= 9)), "answer_window");
    cyc(0, 0, 0, 4'b0000, mk(4'b1000, 3, 1, 0, 0, 1, 1), "timeout_edge");
    for (int i = 101; i <= 112; i++)
      cyc(0, 0, (i == 104), (i == 103) ? 4'b0001 : 4'b0000,
          mk(4'b1000, 3, 1, 0, 0, 1, (i <= 109)), "timeout_hold");
    cyc(0, 1, 0, 4'b0000, Z, "clear_timeout");

    // 6. clear beats capture; reset mid-beep in ANSWER
    cyc(0, 0, 1, 4'b0000, ARM, "arm_clr");
    cyc(0, 1, 0, 4'b0001, Z, "clear_vs_capture");
    cyc(0, 0, 0, 4'b0000, Z, "idle_after_clr");
    cyc(0, 0, 1, 4'b0000, ARM, "arm_rst");
    cyc(0, 0, 0, 4'b0001, mk(4'b0001, 0, 1, 0, 0, 0, 1), "capture_p0");
    for (int i = 1; i <= 3; i++)
      cyc(0, 0, 0, 4'b0000, mk(4'b0001, 0, 1, 0, 0, 0, 1), "answer_p0");
    cyc(1, 0, 0, 4'b0010, Z, "rst_mid_beep");
    cyc(1, 0, 1, 4'b0000, Z, "rst_hold");
    cyc(0, 0, 0, 4'b0000, Z, "post_rst");
    cyc(0, 0, 0, 4'b0000, Z, "post_rst2");

    drive_done = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/quiz_arbiter.md
Name: quiz_arbiter

Overview:
Downstream consumer of key_filter in the responder design. Takes the per-player debounced press pulses plus host start/clear pulses, and decides the first valid responder. It then locks out the other players, drives the winner LEDs and buzzer, and times the answer window. All outputs are registered and drive board LEDs and the buzzer directly.

Parameters:
ANSWER_CYCLES, 500_000_000, answer-window length in clk cycles (10 s at 50 MHz); counter width = clog2(ANSWER_CYCLES+1)
BEEP_CYCLES, 10_000_000, buzzer pulse length in clk cycles (200 ms at 50 MHz); must be >= 1

Ports:
clk  input  1  system clock, 50 MHz
rst  input  1  synchronous reset, active-high
key_flag  input  4  one-cycle press pulse per player from key_filter; bit i = player i
start_flag  input  1  one-cycle host "start question" pulse (debounced)
clear_flag  input  1  one-cycle host "clear/new round" pulse (debounced)
led  output  4  winner one-hot, or mask of fouling players
winner_id  output  2  binary index of winner; valid only while winner_valid=1
winner_valid  output  1  high from capture until clear
armed  output  1  high while in ARMED
foul  output  1  high while in FOUL
timeout  output  1  high while in TIMEOUT
beep  output  1  buzzer drive

Behaviour:
- Reset: synchronous, sampled on the clk rising edge while rst=1. State=IDLE. Outputs led=4'b0000, winner_id=0, winner_valid=0, armed=0, foul=0, timeout=0, beep=0. Both counters cleared. rst overrides every other input.
- Latency: an input sampled at edge t is reflected in state and outputs after edge t (visible in cycle t+1). There is no combinational path from inputs to outputs.
- Input priority per cycle: rst > clear_flag > start_flag > key_flag.
- States: IDLE, ARMED, ANSWER, FOUL, TIMEOUT.
- IDLE:
  - start_flag -> ARMED, armed=1.
  - else key_flag!=0 -> FOUL: led=key_flag (all bits set that cycle), foul=1, beep starts.
  - start_flag and key_flag in the same cycle -> ARMED only; the key is discarded (no foul, no capture).
- ARMED:
  - key_flag!=0 -> ANSWER: winner = lowest-index set bit. Simultaneous presses resolve to the lowest index (4'b1010 -> player 1).
  - On capture: led=one-hot(winner), winner_id=index, winner_valid=1, armed=0, beep starts, answer counter loaded.
  - start_flag is ignored.
- ANSWER:
  - key_flag and start_flag are ignored; led/winner_id are held.
  - The answer counter increments every cycle. At ANSWER_CYCLES cycles after entry -> TIMEOUT: timeout=1, beep restarts; led/winner_id/winner_valid are held.
- FOUL and TIMEOUT: all inputs except clear/rst are ignored; outputs are held.
- clear_flag from any state -> IDLE next edge. All outputs return to reset values, beep stops immediately, counters clear. A clear coinciding with capture or timeout wins: the capture or timeout does not occur.
- Beep:
  - Asserted for exactly BEEP_CYCLES consecutive cycles from each start event (foul, capture, timeout).
  - A new start event while beep is active reloads the count to full length.
  - Beep is independent of the answer counter.
- Counters never wrap. The answer counter stops at the terminal value in TIMEOUT; the beep counter stops at 0.

Test Plan:
Run all scenarios with ANSWER_CYCLES=100 and BEEP_CYCLES=10.
1. Reset: rst=1 for 3 cycles with key_flag=4'b1111 -> all outputs 0 and state IDLE. After release with no input, outputs stay 0.
2. Normal capture: start_flag pulse -> armed=1 next cycle. Then key_flag=4'b0100 -> led=4'b0100, winner_id=2, winner_valid=1, armed=0, and beep high exactly 10 cycles. A later key_flag=4'b0001 leaves led unchanged.
3. Tie and priority:
   - key_flag=4'b1010 while ARMED -> winner_id=1, led=4'b0010.
   - Same cycle start_flag+key_flag=4'b0001 in IDLE -> armed=1, foul=0.
4. Foul: key_flag=4'b1001 in IDLE -> foul=1, led=4'b1001, beep 10 cycles. start_flag is ignored. clear_flag -> all outputs 0 on the next cycle.
5. Timeout: capture player 3, then wait -> timeout=1 exactly 100 cycles after winner_valid rose. led stays 4'b1000, beep high 10 more cycles.
6. Clear collisions and mid-operation reset:
   - clear_flag with key_flag=4'b0001 while ARMED -> IDLE, winner_valid=0, no foul.
   - rst asserted mid-beep in ANSWER -> beep=0 and led=0 on the next cycle.
